// File: rtl/grid_image_reader.sv
// Reader side of the 28x28 one-bit drawing canvas. On a start pulse it walks
// the canvas in raster order through a 1-cycle-latency read port and streams
// each pixel as an 8-bit activation on a valid/ready interface. It also keeps
// a count of set pixels for the HEX/LEDR debug display.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; ones_count holds the last frame's total
// FETCH   | read strobe high for exactly this cycle, address = index
// CAPTURE | read data valid; load the output register and raise out_valid
// SEND    | hold the output until out_ready, then advance or finish
// DONE    | one-cycle done pulse, then back to IDLE
module grid_image_reader #(
   parameter int                    GRID_SIZE  = 28,
   parameter int                    NUM_PIXELS = GRID_SIZE * GRID_SIZE,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] PIXEL_ON   = 8'd255,
   parameter logic [DATA_WIDTH-1:0] PIXEL_OFF  = 8'd0
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  start,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                  mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ones_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SEND,
      DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] index;

   // Frame sequencer. Every output is set on the transition into the state
   // that owns it, so mem_rd_en is high exactly while in FETCH and done is
   // high exactly while in DONE. The read strobe is only raised after the
   // previous pixel has been accepted, so at most one read is outstanding.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         index       <= '0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         out_valid   <= 1'b0;
         out_data    <= PIXEL_OFF;
         out_index   <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ones_count  <= '0;
      end else begin
         mem_rd_en <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  index       <= '0;
                  ones_count  <= '0;
                  busy        <= 1'b1;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= '0;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               out_data  <= mem_rd_data ? PIXEL_ON : PIXEL_OFF;
               out_index <= index;
               out_last  <= (index == LAST_IDX);
               out_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (out_data == PIXEL_ON) begin
                     ones_count <= ones_count + ADDR_WIDTH'(1);
                  end
                  if (index == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     index       <= index + ADDR_WIDTH'(1);
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= index + ADDR_WIDTH'(1);
                     state       <= FETCH;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grid_image_reader.sv
// Bench for grid_image_reader: a behavioural canvas memory plus a raster-order
// reference of the expected pixel stream, driven with random backpressure.
module tb_grid_image_reader;

   localparam int N = 784;

   logic       CLOCK_50;
   logic       reset;
   logic       start;
   logic       mem_rd_en;
   logic [9:0] mem_rd_addr;
   logic       mem_rd_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [9:0] out_index;
   logic       out_last;
   logic       busy;
   logic       done;
   logic [9:0] ones_count;

   int checks = 0;
   int errors = 0;

   bit canvas [N];
   int exp_ones;

   grid_image_reader dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .start       (start),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .ones_count  (ones_count)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // canvas memory with one cycle of read latency
   always @(posedge CLOCK_50) begin
      if (mem_rd_en) mem_rd_data <= canvas[mem_rd_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: blank, 1: four corners, 2: checkerboard, 3: random
   task automatic build_canvas(input int mode);
      exp_ones = 0;
      for (int r = 0; r < 28; r++) begin
         for (int c = 0; c < 28; c++) begin
            bit px;
            case (mode)
               1:       px = (r == 0 || r == 27) && (c == 0 || c == 27);
               2:       px = ((r + c) % 2) == 1;
               3:       px = ($urandom_range(0, 1) == 1);
               default: px = 1'b0;
            endcase
            canvas[r * 28 + c] = px;
            if (px) exp_ones++;
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_rd_en"},  mem_rd_en,   0);
      check_eq({tag, "_rd_addr"}, mem_rd_addr, 0);
      check_eq({tag, "_valid"},  out_valid,   0);
      check_eq({tag, "_data"},   out_data,    0);
      check_eq({tag, "_index"},  out_index,   0);
      check_eq({tag, "_last"},   out_last,    0);
      check_eq({tag, "_busy"},   busy,        0);
      check_eq({tag, "_done"},   done,        0);
      check_eq({tag, "_ones"},   ones_count,  0);
   endtask

   // Streams one frame. Cycle 0 is the cycle start is driven in.
   task automatic run_frame(input string tag, input int ready_pct, input bit repulse);
      int         cyc = 0, xfers = 0, rd_cnt = 0, done_cnt = 0, tail = 0;
      int         first_rd = -1, first_v = -1, done_cyc = -1;
      bit         stalled = 0, pulse_next = 0;
      logic [7:0] held_d = '0;
      logic [9:0] held_i = '0;
      @(posedge CLOCK_50); #1;
      start     = 1'b1;
      out_ready = 1'b0;
      while (tail < 6) begin
         @(posedge CLOCK_50); #1;
         cyc++;
         start = 1'b0;
         if (pulse_next || (repulse && done)) start = 1'b1;
         pulse_next = 0;
         out_ready  = ($urandom_range(0, 99) < ready_pct);
         @(negedge CLOCK_50);
         if (done_cnt > 0) begin
            tail++;
            check_eq({tag, "_idle_activity"}, mem_rd_en | out_valid, 0);
            check_eq({tag, "_idle_busy"}, busy, 0);
            check_eq({tag, "_idle_ones"}, ones_count, exp_ones);
         end
         if (stalled) begin
            check_eq({tag, "_stall_valid"}, out_valid, 1);
            check_eq({tag, "_stall_data"}, out_data, held_d);
            check_eq({tag, "_stall_index"}, out_index, held_i);
         end
         if (mem_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            check_eq({tag, "_rd_while_valid"}, out_valid, 0);
            check_eq({tag, "_rd_addr"}, mem_rd_addr, xfers);
         end
         if (out_valid) begin
            if (first_v < 0) first_v = cyc;
            if (out_ready) begin
               check_eq({tag, "_index"}, out_index, xfers);
               check_eq({tag, "_data"}, out_data, canvas[xfers] ? 255 : 0);
               check_eq({tag, "_last"}, out_last, (xfers == N - 1) ? 1 : 0);
               xfers++;
               stalled = 0;
               if (repulse && xfers == 100) pulse_next = 1;
            end else begin
               stalled = 1;
               held_d  = out_data;
               held_i  = out_index;
            end
         end else begin
            stalled = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq({tag, "_done_xfers"}, xfers, N);
         end
         if (cyc > 20000) begin
            check_eq({tag, "_timeout_done"}, done_cnt, 1);
            break;
         end
      end
      check_eq({tag, "_xfers"}, xfers, N);
      check_eq({tag, "_reads"}, rd_cnt, N);
      check_eq({tag, "_done_count"}, done_cnt, 1);
      check_eq({tag, "_ones_count"}, ones_count, exp_ones);
      if (ready_pct >= 100) begin
         check_eq({tag, "_lat_rd"}, first_rd, 1);
         check_eq({tag, "_lat_valid"}, first_v, 3);
         check_eq({tag, "_lat_done"}, done_cyc, 2353);
      end
   endtask

   initial begin
      bit found;
      reset       = 1'b1;
      start       = 1'b0;
      out_ready   = 1'b0;
      mem_rd_data = 1'b0;
      build_canvas(0);
      repeat (3) @(posedge CLOCK_50);
      #1;
      check_reset_values("por");
      reset = 1'b0;

      build_canvas(0);
      run_frame("blank", 100, 0);

      build_canvas(1);
      run_frame("corners", 100, 0);
      check_eq("corners_model", exp_ones, 4);

      build_canvas(2);
      run_frame("checker", 30, 0);

      build_canvas(3);
      run_frame("restart", 70, 1);

      // reset while index 500 is waiting in SEND
      build_canvas(3);
      @(posedge CLOCK_50); #1;
      start     = 1'b1;
      out_ready = 1'b1;
      found     = 0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(posedge CLOCK_50); #1;
         start = 1'b0;
         if (out_valid && out_index == 10'd500) found = 1;
      end
      check_eq("mid_reset_reach", found, 1);
      out_ready = 1'b0;
      reset     = 1'b1;
      @(posedge CLOCK_50); #1;
      check_reset_values("mid_reset");
      reset = 1'b0;
      build_canvas(3);
      run_frame("after_reset", 100, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/grid_image_reader.md
Name: grid_image_reader

Overview:
- Reader side of the 28x28 one-bit drawing canvas; the drawing/VGA front end is the writer.
- On a start pulse, scans canvas memory in raster order (index = row*GRID_SIZE + col, 0..783) through a synchronous 1-cycle-latency read port.
- Emits each pixel as an 8-bit activation on a valid/ready stream feeding the neural-network input layer.
- Reports completion and a count of set pixels for HEX/LEDR debug.

Parameters:
- GRID_SIZE, 28, canvas edge length in cells.
- NUM_PIXELS, GRID_SIZE*GRID_SIZE (784), pixels per frame.
- ADDR_WIDTH, 10, width of the memory address, out_index and ones_count.
- DATA_WIDTH, 8, width of out_data.
- PIXEL_ON, 8'd255, out_data value for a set (drawn) pixel.
- PIXEL_OFF, 8'd0, out_data value for a clear pixel.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to stream one frame; honoured only in IDLE.
- mem_rd_en  out  1  read strobe to canvas memory.
- mem_rd_addr  out  ADDR_WIDTH  read address, raster index.
- mem_rd_data  in  1  pixel bit, valid the cycle after mem_rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_data  out  DATA_WIDTH  PIXEL_ON or PIXEL_OFF.
- out_index  out  ADDR_WIDTH  raster index of out_data.
- out_last  out  1  high with out_valid when out_index == NUM_PIXELS-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final transfer.
- ones_count  out  ADDR_WIDTH  number of PIXEL_ON transfers in the current or last frame.

Behaviour:
- All outputs registered.
- Reset values: mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, ones_count=0, state=IDLE, internal index=0.
- States: IDLE, FETCH, CAPTURE, SEND, DONE.
- IDLE:
  - On start=1: index<=0, ones_count<=0, go to FETCH.
  - Otherwise hold; ones_count retains the last frame's value.
- FETCH: mem_rd_en=1 and mem_rd_addr=index for exactly this one cycle; go to CAPTURE.
- CAPTURE:
  - Sample mem_rd_data.
  - Load out_data (PIXEL_ON if bit is 1, else PIXEL_OFF), out_index<=index, out_last<=(index==NUM_PIXELS-1).
  - Set out_valid; go to SEND.
- SEND:
  - While out_ready=0: out_valid, out_data, out_index and out_last held stable.
  - On out_valid & out_ready: out_valid<=0; ones_count increments if out_data==PIXEL_ON.
  - After that transfer: if index==NUM_PIXELS-1 go to DONE, else index<=index+1 and go to FETCH.
- DONE: done=1 for this cycle only; go to IDLE.
- Timing:
  - Start sampled at edge k: mem_rd_en high during cycle k+1; first out_valid visible after edge k+3.
  - With out_ready held high: 3 cycles per pixel; done pulses 2353 cycles after start acceptance.
- Index arithmetic: unsigned ADDR_WIDTH; never exceeds NUM_PIXELS-1, no wrap.
- start while busy (including the DONE cycle): ignored, no effect on the frame in progress.
- mem_rd_en is never asserted while out_valid=1 (at most one read outstanding).
- reset mid-frame: next cycle in IDLE with reset values; no done pulse; partial ones_count cleared.
- reset and start together: reset wins.
- out_ready asserted while out_valid=0: no effect.

Test Plan:
- All-zero canvas, out_ready=1, start pulse:
  - 784 transfers, all out_data=0, out_index 0..783 in order.
  - out_last only on index 783; done pulse once; ones_count=0; busy low after done.
- Canvas with only (row0,col0), (row0,col27), (row27,col0) and (row27,col27) set:
  - out_data=255 exactly at indices 0, 27, 756 and 783; ones_count=4.
- Random backpressure (out_ready ~30% high) on a checkerboard canvas:
  - out_data/out_index stable while stalled; no lost or duplicated index.
  - ones_count=392; at most one mem_rd_en per transfer.
- start re-pulsed at transfer 100 and during the DONE cycle:
  - Stream continues unaffected, one done pulse, no second frame.
- reset asserted in SEND at index 500:
  - All outputs at reset values next cycle; a new start streams from index 0 with correct data.
- Latency check, out_ready=1:
  - mem_rd_en first high 1 cycle after start; out_valid first high 3 cycles after start.
  - done exactly 2353 cycles after start.
